// File: rtl/risc_pkg.sv
// Shared definitions for the instruction-stream loader: word geometry and
// the loader FSM state encoding.
package risc_pkg;

    localparam int XLEN       = 32;
    localparam int WORD_BYTES = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_COUNT = 3'd1,
        ST_DATA  = 3'd2,
        ST_WRITE = 3'd3,
        ST_CHECK = 3'd4,
        ST_DONE  = 3'd5
    } load_state_e;

endpackage

// File: rtl/instr_stream_loader_word_assembler.sv
// Packs a byte stream little-endian into one instruction word. The byte
// index selects the lane the next byte lands in; word_next_o is the word as
// it will look after the current byte is shifted in, so the parent can
// capture a completed word on the same edge the last byte arrives.
module word_assembler
    import risc_pkg::*;
#(
    parameter int WORD_BYTES = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear_i,
    input  logic                      shift_i,
    input  logic [7:0]                byte_i,
    output logic [WORD_BYTES*8-1:0]   word_next_o,
    output logic                      word_full_o
);

    localparam int IW = $clog2(WORD_BYTES);

    logic [WORD_BYTES*8-1:0] lanes_q, lanes_d;
    logic [IW-1:0]           idx_q, idx_d;

    // Lane merge and index advance; clear wins over shift.
    always_comb begin
        lanes_d     = lanes_q;
        idx_d       = idx_q;
        word_next_o = lanes_q;
        word_next_o[{idx_q, 3'b000} +: 8] = byte_i;
        if (clear_i) begin
            lanes_d = '0;
            idx_d   = '0;
        end else if (shift_i) begin
            lanes_d = word_next_o;
            idx_d   = idx_q + IW'(1);
        end
    end

    // High when the byte about to be shifted completes the word.
    assign word_full_o = (idx_q == IW'(WORD_BYTES - 1));

    // Lane register and byte index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lanes_q <= '0;
            idx_q   <= '0;
        end else begin
            lanes_q <= lanes_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: rtl/instr_stream_loader.sv
// Loads a framed byte stream (count, little-endian words, XOR checksum) into
// instruction memory and releases the CPU only after a clean load.
// Handshake: a byte moves on a rising clk edge when byte_valid && byte_ready;
// byte_ready depends on state only (high in COUNT, DATA, CHECK), so the
// sender may stall freely and never sees ready depend on its own valid.
module instr_stream_loader
    import risc_pkg::*;
#(
    parameter int ADDR_WIDTH = 7,
    parameter int WORD_BYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_start,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [XLEN-1:0]       mem_wdata,
    output logic                  cpu_hold,
    output logic                  load_done,
    output logic                  load_err
);

    // One extra bit so a full-capacity count (2**ADDR_WIDTH) is representable
    // and the last address is all-ones without wrapping.
    localparam int          CW       = ADDR_WIDTH + 1;
    localparam logic [31:0] CAPACITY = 32'd1 << ADDR_WIDTH;

    load_state_e           state_q, state_d;
    logic [CW-1:0]         word_cnt_q, word_cnt_d;
    logic [CW-1:0]         n_q, n_d;
    logic [7:0]            csum_q, csum_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [XLEN-1:0]       wdata_q, wdata_d;
    logic                  hold_q, hold_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic                  xfer;
    logic                  asm_clear;
    logic                  asm_shift;
    logic                  asm_full;
    logic [XLEN-1:0]       asm_word_next;
    logic [31:0]           count_ext;
    logic [CW-1:0]         word_cnt_inc;

    word_assembler #(
        .WORD_BYTES (WORD_BYTES)
    ) u_asm (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (asm_clear),
        .shift_i     (asm_shift),
        .byte_i      (byte_data),
        .word_next_o (asm_word_next),
        .word_full_o (asm_full)
    );

    // Handshake and output views of the registered state.
    assign byte_ready   = (state_q == ST_COUNT) || (state_q == ST_DATA) || (state_q == ST_CHECK);
    assign xfer         = byte_valid && byte_ready;
    assign mem_we       = (state_q == ST_WRITE);
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign cpu_hold     = hold_q;
    assign load_done    = done_q;
    assign load_err     = err_q;
    assign count_ext    = {24'd0, byte_data};
    assign word_cnt_inc = word_cnt_q + CW'(1);

    // Next-state, datapath updates and assembler controls for the load FSM.
    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        n_d        = n_q;
        csum_d     = csum_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        hold_d     = hold_q;
        done_d     = done_q;
        err_d      = err_q;
        asm_clear  = 1'b0;
        asm_shift  = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (load_start) begin
                    state_d    = ST_COUNT;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                    hold_d     = 1'b1;
                    word_cnt_d = '0;
                    n_d        = '0;
                    csum_d     = 8'd0;
                    asm_clear  = 1'b1;
                end
            end
            ST_COUNT: begin
                if (xfer) begin
                    if (byte_data == 8'd0) begin
                        state_d = ST_CHECK;
                    end else if (count_ext > CAPACITY) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        n_d     = count_ext[CW-1:0];
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (xfer) begin
                    asm_shift = 1'b1;
                    csum_d    = csum_q ^ byte_data;
                    if (asm_full) begin
                        // Capture the completed word now so it is stable
                        // for the whole WRITE cycle and held afterwards.
                        state_d = ST_WRITE;
                        addr_d  = word_cnt_q[ADDR_WIDTH-1:0];
                        wdata_d = asm_word_next;
                    end
                end
            end
            ST_WRITE: begin
                word_cnt_d = word_cnt_inc;
                state_d    = (word_cnt_inc == n_q) ? ST_CHECK : ST_DATA;
            end
            ST_CHECK: begin
                if (xfer) begin
                    if (byte_data == csum_q) begin
                        done_d = 1'b1;
                        hold_d = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset leaves the CPU held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            word_cnt_q <= '0;
            n_q        <= '0;
            csum_q     <= 8'd0;
            addr_q     <= '0;
            wdata_q    <= '0;
            hold_q     <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            n_q        <= n_d;
            csum_q     <= csum_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            hold_q     <= hold_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: doc/instr_stream_loader.md
Name: instr_stream_loader

Overview:
- Upstream feeder for the instruction memory of the RISC core on the Tiny Tapeout tile.
- Accepts a framed byte stream from the pad inputs and packs bytes little-endian into 32-bit words.
- Writes each word into consecutive instruction-memory addresses and checks a trailing XOR checksum.
- Holds the CPU in reset until a load completes cleanly. Byte order matches the low-byte-first output serializer on uo_out.

Parameters:
- ADDR_WIDTH, 7, word-address width of instruction memory; capacity = 2**ADDR_WIDTH words.
- WORD_BYTES, 4, bytes per instruction word (fixed at 4 for RV32; the parameter exists for the assembler).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- load_start  in  1  one-cycle request to begin a load; honoured only in IDLE or DONE.
- byte_valid  in  1  byte_data is valid this cycle.
- byte_data  in  8  stream byte.
- byte_ready  out  1  loader accepts byte_data this cycle.
- mem_we  out  1  instruction-memory write strobe, one cycle per word.
- mem_addr  out  ADDR_WIDTH  word address of the write.
- mem_wdata  out  32  assembled word.
- cpu_hold  out  1  keeps the CPU in reset while high.
- load_done  out  1  sticky: load finished with a good checksum.
- load_err  out  1  sticky: bad count or checksum mismatch.

Behaviour:
- Reset values: byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=1, load_done=0, load_err=0. FSM enters IDLE; counters and checksum are cleared.
- Transfer rule: a byte transfers when byte_valid && byte_ready on a rising clk edge. byte_ready is combinational from state: high in COUNT, DATA and CHECK; low elsewhere.
- Frame format: count byte N (number of words), then N*4 data bytes with the LSB of each word first, then one checksum byte. The checksum is the XOR of all data bytes; the count byte is excluded.
- IDLE/DONE:
  - load_start moves to COUNT next cycle.
  - On that move: clear load_done, load_err, word counter, byte index and checksum; drive cpu_hold=1.
  - load_start in any other state is ignored.
- COUNT (on transfer):
  - N=0: go to CHECK.
  - N > 2**ADDR_WIDTH: set load_err and go to DONE.
  - Otherwise latch N and go to DATA.
- DATA:
  - Each transfer shifts the byte into lane byte_index and XORs it into the checksum.
  - On the 4th byte, go to WRITE.
- WRITE (exactly one cycle):
  - mem_we=1, mem_addr = word counter, mem_wdata = assembled word. byte_ready=0.
  - Then increment the word counter. Go to CHECK if counter+1 == N, else DATA.
- CHECK (on transfer):
  - Byte equals the running checksum: set load_done, clear cpu_hold.
  - Otherwise: set load_err, keep cpu_hold=1.
  - Go to DONE in both cases.
- Throughput and latency:
  - Throughput is 4 bytes per 5 cycles at best; byte_valid may stall arbitrarily.
  - The memory write occurs 1 cycle after the 4th byte of a word is accepted.
  - load_done/cpu_hold update 1 cycle after the checksum byte is accepted.
- Address width: mem_addr never wraps. N == 2**ADDR_WIDTH writes up to the all-ones address; the counter is ADDR_WIDTH+1 bits internally.
- mem_wdata and mem_addr hold their last values outside WRITE; mem_we is low outside WRITE.
- load_start during a load is ignored; there is no abort. An abort requires rst.
- Mid-load rst: all outputs return to reset values. Partially written memory words remain; the CPU stays held.

Decomposition:
- Shared package (risc_pkg):
  - FSM state encoding (IDLE, COUNT, DATA, WRITE, CHECK, DONE).
  - WORD_BYTES constant.
  - XLEN = 32.
- Sub-module word_assembler:
  - Holds the byte-lane register and the 2-bit byte index.
  - Has clear, shift-enable and a word_full output.
- The FSM, counters and checksum stay in instr_stream_loader.

Test Plan:
- Single word, clean checksum:
  - Stimulus: load_start, then bytes 0x01, 0x13, 0x05, 0x50, 0x00, 0x46 with byte_valid held high.
  - Required response: one mem_we with addr=0, wdata=0x00500513; load_done=1; cpu_hold=0; load_err=0.
- Bad checksum:
  - Stimulus: same frame with checksum 0x47.
  - Required response: word written at addr 0; load_err=1; load_done=0; cpu_hold stays 1.
- Zero count:
  - Stimulus: bytes 0x00, 0x00.
  - Required response: no mem_we; load_done=1; cpu_hold=0.
- Oversize count:
  - Stimulus: count 0x81 with ADDR_WIDTH=7.
  - Required response: load_err=1 after the count byte; no mem_we; later bytes not accepted (byte_ready=0).
- Full memory with stalls:
  - Stimulus: N=128, random byte_valid gaps.
  - Required response: 128 writes at addr 0..127 in order, each wdata matching the packed bytes; byte_ready=0 in every WRITE cycle; load_done=1.
- Mid-load reset and restart:
  - Stimulus: rst asserted during DATA of word 2.
  - Required response: outputs at reset values immediately (asynchronous reset). A following load_start with a fresh 1-word frame completes correctly at addr 0.
